// File: rtl/pulse_scheduler.sv
// pulse_scheduler: per-channel pulse train sequencer.
// Arms on enable, starts on the PPS whose RTC time equals the user start time,
// then emits high/period pulses timed in microseconds from a clock prescaler.
// Shadow copies of high/period are taken only at train start and at period
// boundaries, so register writes never disturb the period in progress.
//
// Handshake/strobe semantics: there is no valid/ready pair. i_pps is a
// one-cycle strobe and i_rtc_time is only meaningful in that cycle; the
// configuration inputs are level signals sampled at the points noted above.
module pulse_scheduler #(
  parameter int CLK_PER_US = 100,
  parameter int US_WIDTH   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_pulse_enable,
  input  logic [55:0]         i_usr_time,
  input  logic [55:0]         i_rtc_time,
  input  logic                i_pps,
  input  logic [US_WIDTH-1:0] i_width_high,
  input  logic [US_WIDTH-1:0] i_width_period,
  output logic                o_pulse,
  output logic                o_armed,
  output logic                o_running,
  output logic                o_cfg_err
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0]       PRESC_LAST = PW'(CLK_PER_US - 1);
  localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);
  localparam logic [US_WIDTH-1:0] US_ONE     = US_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PW-1:0]       r_presc;
  logic [US_WIDTH-1:0] r_us_cnt;
  logic [US_WIDTH-1:0] r_sh_high;
  logic [US_WIDTH-1:0] r_sh_period;
  logic                r_cfg_err;
  logic                r_pulse;

  logic w_en;
  logic w_cfg_valid;
  logic w_running;
  logic w_running_nxt;
  logic w_us_tick;
  logic w_match;
  logic w_high_end;
  logic w_period_end;
  logic w_unused_en;

  // Only bit 0 of the enable register is meaningful.
  assign w_en        = i_pulse_enable[0];
  assign w_unused_en = ^i_pulse_enable[7:1];

  assign w_cfg_valid   = (i_width_high != '0) && (i_width_high < i_width_period);
  assign w_running     = (r_state == S_HIGH) || (r_state == S_LOW);
  assign w_running_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW);
  assign w_us_tick     = w_running && (r_presc == PRESC_LAST);
  assign w_match       = i_pps && (i_rtc_time == i_usr_time);
  assign w_high_end    = w_us_tick && (r_us_cnt == r_sh_high - US_ONE);
  assign w_period_end  = w_us_tick && (r_us_cnt == r_sh_period - US_ONE);

  // Next-state decode; a low enable bit overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cfg_valid)  w_state_nxt = S_ARMED;
        S_ARMED: if (w_match)      w_state_nxt = S_HIGH;
        S_HIGH:  if (w_high_end)   w_state_nxt = S_LOW;
        S_LOW:   if (w_period_end) w_state_nxt = S_HIGH;
        default:                   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, output pulse, timing counters, shadows and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pulse     <= 1'b0;
      r_presc     <= '0;
      r_us_cnt    <= '0;
      r_sh_high   <= '0;
      r_sh_period <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= (w_state_nxt == S_HIGH);

      // Counters only advance while a train continues; any entry into the
      // train (or leaving it) starts them from zero.
      if (w_running && w_running_nxt) begin
        r_presc <= w_us_tick ? '0 : r_presc + PRESC_ONE;
        if (w_period_end)   r_us_cnt <= '0;
        else if (w_us_tick) r_us_cnt <= r_us_cnt + US_ONE;
      end else begin
        r_presc  <= '0;
        r_us_cnt <= '0;
      end

      // Shadows are captured at start and at each period boundary; at a
      // boundary an invalid configuration is rejected and the old one kept.
      if (w_en && (r_state == S_ARMED) && w_match) begin
        r_sh_high   <= i_width_high;
        r_sh_period <= i_width_period;
      end else if (w_en && (r_state == S_LOW) && w_period_end && w_cfg_valid) begin
        r_sh_high   <= i_width_high;
        r_sh_period <= i_width_period;
      end

      if (!w_en) begin
        r_cfg_err <= 1'b0;
      end else if ((r_state == S_IDLE) && !w_cfg_valid) begin
        r_cfg_err <= 1'b1;
      end else if ((r_state == S_LOW) && w_period_end && !w_cfg_valid) begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  assign o_pulse   = r_pulse;
  assign o_armed   = (r_state == S_ARMED);
  assign o_running = w_running;
  assign o_cfg_err = r_cfg_err;

endmodule
